// File: rtl/lab2_5_event_monitor_if.sv
// Handshake/report bundle between the sequence detector, the event monitor and
// the report consumer. The monitor is the slave; the surrounding logic is the master.
interface lab2_5_event_monitor_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             stop;
  logic             z;
  logic             error;
  logic             D;
  logic             rpt_ready;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] err_count;
  logic             d_last;
  logic             rpt_valid;
  logic             overrun;
  logic             alarm;
  logic             busy;

  modport master (
    output start, stop, z, error, D, rpt_ready,
    input  hit_count, err_count, d_last, rpt_valid, overrun, alarm, busy
  );

  modport slave (
    input  start, stop, z, error, D, rpt_ready,
    output hit_count, err_count, d_last, rpt_valid, overrun, alarm, busy
  );
endinterface

// File: rtl/lab2_5_event_monitor.sv
// Windowed event monitor: counts z rising edges and error cycles per WINDOW clocks
// and hands each window's result to a consumer over a valid/ready report interface.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | not counting; a pending report can still be drained
//   RUN   | counting windows back to back; busy=1
module lab2_5_event_monitor #(
  parameter int WINDOW    = 16,
  parameter int CNT_W     = 4,
  parameter int ERR_LIMIT = 3
) (
  input logic                    clock,
  input logic                    reset_n,
  lab2_5_event_monitor_if.slave  mon
);

  localparam int               WW    = $clog2(WINDOW);
  localparam logic [WW-1:0]    WLAST = WW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [31:0]      ELIM  = ERR_LIMIT;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] live_hit;
  logic [CNT_W-1:0] live_err;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] err_q;
  logic             z_q;
  logic             d_last_q;
  logic             valid_q;
  logic             overrun_q;
  logic             alarm_q;
  logic             busy_q;

  logic             hit_ev;
  logic [CNT_W-1:0] hit_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic             err_over;
  logic             xfer;
  logic             can_load;

  // Counts including the current cycle's events, saturated so a window end
  // reports exactly what the window saw.
  assign hit_ev   = mon.z & ~z_q;
  assign hit_nxt  = (live_hit == CMAX) ? CMAX : live_hit + CNT_W'(hit_ev);
  assign err_nxt  = (live_err == CMAX) ? CMAX : live_err + CNT_W'(mon.error);
  assign err_over = 32'(err_nxt) >= ELIM;
  assign xfer     = valid_q & mon.rpt_ready;
  assign can_load = ~valid_q | mon.rpt_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      live_hit  <= '0;
      live_err  <= '0;
      hit_q     <= '0;
      err_q     <= '0;
      z_q       <= 1'b0;
      d_last_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      alarm_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      z_q <= mon.z;
      // A load at window end below overrides this clear.
      if (xfer) valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (mon.start) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            wcnt      <= '0;
            live_hit  <= '0;
            live_err  <= '0;
            overrun_q <= 1'b0;
            alarm_q   <= 1'b0;
          end
        end

        RUN: begin
          if (mon.stop) begin
            // Partial window is abandoned; report registers are left alone.
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (err_over) alarm_q <= 1'b1;
            if (wcnt == WLAST) begin
              wcnt     <= '0;
              live_hit <= '0;
              live_err <= '0;
              if (can_load) begin
                hit_q    <= hit_nxt;
                err_q    <= err_nxt;
                d_last_q <= mon.D;
                valid_q  <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              wcnt     <= wcnt + WW'(1);
              live_hit <= hit_nxt;
              live_err <= err_nxt;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mon.hit_count = hit_q;
  assign mon.err_count = err_q;
  assign mon.d_last    = d_last_q;
  assign mon.rpt_valid = valid_q;
  assign mon.overrun   = overrun_q;
  assign mon.alarm     = alarm_q;
  assign mon.busy      = busy_q;

endmodule

// File: doc/lab2_5_event_monitor.md
Name: lab2_5_event_monitor

Overview:
- Downstream consumer of the lab2_5 sequence detector.
- Takes the detector's z, error and D outputs and counts detections (z rising edges) and error cycles over fixed windows of WINDOW clocks.
- Presents each window's result as a report held under a valid/ready handshake, and raises sticky alarm and overrun flags.

Parameters:
WINDOW, 16, clock cycles per counting window (>=2)
CNT_W, 4, width of hit and error counters (saturating)
ERR_LIMIT, 3, per-window error-cycle count that sets alarm

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins monitoring from IDLE
stop  input  1  one-cycle pulse; returns to IDLE
z  input  1  detector output z
error  input  1  detector error output
D  input  1  detector D output
hit_count  output  CNT_W  reported z rising-edge count
err_count  output  CNT_W  reported error-cycle count
d_last  output  1  D sampled at window-end cycle
rpt_valid  output  1  report registers hold an unconsumed report
rpt_ready  input  1  consumer accepts report
overrun  output  1  sticky: a window result was dropped
alarm  output  1  sticky: ERR_LIMIT reached within a window
busy  output  1  high in RUN state

Behaviour:
- Reset (reset_n=0, async): state=IDLE; window counter, live counters, z_q, hit_count, err_count, d_last, rpt_valid, overrun, alarm, busy all 0.
- z_q <= z every cycle in every state. Hit event = z & ~z_q. The first RUN cycle therefore uses the z value from the IDLE cycle before it.
- FSM states IDLE, RUN:
  - IDLE: start=1 -> RUN. Same edge: wcnt=0, live counters=0, overrun=0, alarm=0. stop is ignored in IDLE. If start and stop are both high in IDLE, start wins.
  - RUN: busy=1. stop=1 -> IDLE next edge. The partial window is discarded; report registers and rpt_valid are untouched. start is ignored in RUN.
  - stop in the same cycle as a window end: stop wins and no report is produced.
- Live counting in RUN:
  - live_hit += hit event.
  - live_err += error.
  - Both saturate at 2^CNT_W-1, with no wrap.
- Window counter wcnt counts 0..WINDOW-1 in RUN. The cycle with wcnt==WINDOW-1 is the window end. Its own events are included in the result. On that edge:
  - wcnt=0 and live counters=0.
  - The result (live values plus this cycle's events, saturated) and D go to the report registers, subject to the report handshake below.
- Report handshake:
  - A transfer occurs on the edge where rpt_valid & rpt_ready.
  - Window end with rpt_valid=0, or rpt_valid=1 and rpt_ready=1 that cycle: load the new report. rpt_valid=1 from the next cycle. No overrun.
  - Window end with rpt_valid=1 and rpt_ready=0: the old report is kept unchanged, the new result is dropped, overrun<=1.
  - Transfer with no window end: rpt_valid<=0.
  - Report outputs stay stable while rpt_valid=1 and no transfer occurs. The handshake stays active in IDLE, so a pending report can be drained after stop.
- Alarm:
  - Set (sticky) on the edge where the live error count, including that cycle's error, becomes >= ERR_LIMIT within the current window.
  - alarm and overrun are cleared only by reset or by start from IDLE.
- Latency: a report appears 1 cycle after the window-end cycle.
- Window throughput: a result is produced every WINDOW cycles, with no dead cycle between windows.

Test Plan:
- Reset mid-RUN with rpt_valid=1: assert reset_n=0 off the clock edge -> all outputs 0 immediately. After release the block stays IDLE until start.
- WINDOW=8, start, z=1 for 2 cycles, 0 for 1 cycle, 1 for 1 cycle, then 0; error=1 for 1 cycle; D=1 at cycle 7 -> rpt_valid rises 1 cycle after the window end with hit_count=2, err_count=1, d_last=1. alarm=0, overrun=0.
- Hold rpt_ready=0 for 2 windows; the second window has hit_count=3 -> first report retained, overrun=1. Then rpt_ready=1 for 1 cycle -> rpt_valid=0.
- CNT_W=2, 5 z pulses and error held high for the whole window -> hit_count=3, err_count=3. alarm=1 after the 3rd error cycle and still 1 after the next window.
- stop asserted at wcnt=5 -> busy=0 next cycle, no new report, prior report still drainable. start again -> overrun and alarm cleared, new window reports correctly.
- start held with z=1 on the IDLE cycle before RUN -> no hit counted for the first RUN cycle if z stays 1.
